sar_conv_sequencer: RTL

Sequences the 12-bit SAR conversion core: opens the sample/hold window, releases the SAR from reset, and waits for conversion-done. It captures the SAR code, optionally averages 2^N back-to-back conversions, and presents the result on a valid/ready handshake. It sits between the chip-level wrapper (trigger/config pins) and the SAR logic instance, and owns the SAR's reset and sample timing.

---
 rtl/sar_seq_pkg.sv | 31 +++
 rtl/sar_seq_accum.sv | 50 +++++
 rtl/sar_conv_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sar_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sar_seq_pkg
//  Brief    : Shared types, widths and helpers for the SAR conversion sequencer
//  Revision : 1.0
// ============================================================================
package sar_seq_pkg;

  localparam int DATA_W       = 12;
  localparam int MAX_AVG_LOG2 = 4;
  localparam int ACC_W        = DATA_W + MAX_AVG_LOG2;
  localparam int AVG_W        = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    OUTPUT  = 2'd3
  } seq_state_t;

  // Requests beyond the supported averaging depth saturate at the maximum.
  function automatic logic [AVG_W-1:0] clamp_avg(input logic [AVG_W-1:0] req,
                                                 input int max_log2);
    if (int'(req) > max_log2) begin
      return AVG_W'(max_log2);
    end
    return req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sar_seq_accum.sv
`default_nettype none
// ============================================================================
//  Module   : sar_seq_accum
//  Brief    : Conversion accumulator, conversion counter and power-of-2 divide
//  Revision : 1.0
// ============================================================================
module sar_seq_accum #(
  parameter int DATA_W       = 12,
  parameter int MAX_AVG_LOG2 = 4,
  parameter int AVG_W        = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              add,
  input  logic [DATA_W-1:0] add_data,
  input  logic [AVG_W-1:0]  avg_log2,
  output logic              last_add,
  output logic [DATA_W-1:0] quotient
);

  localparam int ACC_W = DATA_W + MAX_AVG_LOG2;
  localparam int CNT_W = MAX_AVG_LOG2 + 1;

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_target;

  assign w_target = CNT_W'(1) << avg_log2;

  // High when the conversion being added now completes the 2^avg_log2 set.
  assign last_add = (r_count + CNT_W'(1)) >= w_target;

  assign quotient = DATA_W'(r_acc >> avg_log2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (add) begin
      r_acc   <= r_acc + ACC_W'(add_data);
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sar_conv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sar_conv_sequencer
//  Brief    : Sample/convert sequencing, averaging and result handshake for SAR
//  Revision : 1.0
// ============================================================================
module sar_conv_sequencer #(
  parameter int DATA_W       = sar_seq_pkg::DATA_W,
  parameter int MAX_AVG_LOG2 = sar_seq_pkg::MAX_AVG_LOG2,
  parameter int SAMPLE_W     = 4,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                continuous,
  input  logic [SAMPLE_W-1:0] sample_len,
  input  logic [2:0]          avg_log2,
  input  logic                clr_status,
  input  logic                sar_done,
  input  logic [DATA_W-1:0]   sar_bits,
  output logic                sar_rst,
  output logic                sample_en,
  output logic [DATA_W-1:0]   result,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                busy,
  output logic                trig_miss,
  output logic                timeout_err
);

  import sar_seq_pkg::*;

  localparam int                TMO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]  c_tmo_last = TMO_W'(TIMEOUT_CYC - 1);

  seq_state_t          r_state;
  logic [SAMPLE_W-1:0] r_sample_cnt;
  logic [SAMPLE_W-1:0] r_cfg_len;
  logic [AVG_W-1:0]    r_cfg_avg;
  logic                r_cfg_cont;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic                r_sar_rst;
  logic                r_sample_en;
  logic [DATA_W-1:0]   r_result;
  logic                r_result_valid;
  logic                r_busy;
  logic                r_trig_miss;
  logic                r_timeout_err;

  logic                w_accept;
  logic                w_handshake;
  logic                w_rearm;
  logic                w_acc_clear;
  logic                w_acc_add;
  logic                w_last_add;
  logic                w_trig_set;
  logic                w_tmo_set;
  logic [DATA_W-1:0]   w_quotient;

  assign w_accept    = (r_state == IDLE) && start;
  assign w_handshake = (r_state == OUTPUT) && r_result_valid && result_ready;
  assign w_rearm     = w_handshake && r_cfg_cont;
  assign w_acc_clear = w_accept || w_rearm;
  assign w_acc_add   = (r_state == CONVERT) && sar_done;
  assign w_trig_set  = start && (r_state != IDLE);
  assign w_tmo_set   = (r_state == CONVERT) && !sar_done && (r_tmo_cnt == c_tmo_last);

  sar_seq_accum #(
    .DATA_W       (DATA_W),
    .MAX_AVG_LOG2 (MAX_AVG_LOG2),
    .AVG_W        (AVG_W)
  ) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_acc_clear),
    .add      (w_acc_add),
    .add_data (sar_bits),
    .avg_log2 (r_cfg_avg),
    .last_add (w_last_add),
    .quotient (w_quotient)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_sample_cnt   <= '0;
      r_cfg_len      <= '0;
      r_cfg_avg      <= '0;
      r_cfg_cont     <= 1'b0;
      r_tmo_cnt      <= '0;
      r_sar_rst      <= 1'b1;
      r_sample_en    <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_trig_miss    <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      // Sticky flags: a set event in the same cycle as clr_status wins.
      r_trig_miss   <= (r_trig_miss & ~clr_status) | w_trig_set;
      r_timeout_err <= (r_timeout_err & ~clr_status) | w_tmo_set;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state      <= SAMPLE;
            r_cfg_len    <= sample_len;
            r_cfg_avg    <= clamp_avg(avg_log2, MAX_AVG_LOG2);
            r_cfg_cont   <= continuous;
            r_sample_cnt <= '0;
            r_sample_en  <= 1'b1;
            r_busy       <= 1'b1;
          end
        end

        SAMPLE: begin
          if (r_sample_cnt == r_cfg_len) begin
            r_state     <= CONVERT;
            r_sample_en <= 1'b0;
            r_sar_rst   <= 1'b0;
            r_tmo_cnt   <= '0;
          end else begin
            r_sample_cnt <= r_sample_cnt + SAMPLE_W'(1);
          end
        end

        CONVERT: begin
          if (sar_done) begin
            r_sar_rst <= 1'b1;
            if (w_last_add) begin
              r_state <= OUTPUT;
            end else begin
              r_state      <= SAMPLE;
              r_sample_cnt <= '0;
              r_sample_en  <= 1'b1;
            end
          end else if (r_tmo_cnt == c_tmo_last) begin
            r_state   <= IDLE;
            r_sar_rst <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end

        OUTPUT: begin
          // First OUTPUT cycle loads the divided sum; valid follows one clock after entry.
          if (!r_result_valid) begin
            r_result       <= w_quotient;
            r_result_valid <= 1'b1;
          end else if (result_ready) begin
            r_result_valid <= 1'b0;
            if (r_cfg_cont) begin
              r_state      <= SAMPLE;
              r_cfg_len    <= sample_len;
              r_cfg_avg    <= clamp_avg(avg_log2, MAX_AVG_LOG2);
              r_cfg_cont   <= continuous;
              r_sample_cnt <= '0;
              r_sample_en  <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign sar_rst      = r_sar_rst;
  assign sample_en    = r_sample_en;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;
  assign trig_miss    = r_trig_miss;
  assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire
